// File: rtl/memory_referee.sv
// Referee for the pairs game: turn order, scoring, turn timeout and an
// end-of-game scan that produces a winner mask and tie flag.
module memory_referee #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int TURN_TICKS  = 4,
  localparam int SCORE_W    = $clog2(NUM_PAIRS + 1),
  localparam int PID_W      = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           turn_valid,
  input  logic                           turn_match,
  input  logic                           tick,
  output logic [PID_W-1:0]               current_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [SCORE_W-1:0]             pairs_found,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_PLAYERS-1:0]         winner_mask,
  output logic                           tie,
  output logic                           timeout_pulse
);

  typedef enum logic [1:0] {IDLE, PLAY, EVAL, DONE} state_t;

  localparam logic [PID_W-1:0]   LAST_PID   = PID_W'(NUM_PLAYERS - 1);
  localparam logic [SCORE_W-1:0] PAIRS_MAX  = SCORE_W'(NUM_PAIRS);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [7:0]         TICKS_MAX  = 8'(TURN_TICKS);
  localparam bit                 TIMEOUT_EN = (TURN_TICKS > 0);

  state_t                   state_q;
  logic [PID_W-1:0]         player_q;
  logic [SCORE_W-1:0]       score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]       pairs_q;
  logic [7:0]               timer_q;
  logic [PID_W-1:0]         scanIdx_q;
  logic [SCORE_W-1:0]       max_q;
  logic [NUM_PLAYERS-1:0]   mask_q;
  logic [NUM_PLAYERS-1:0]   winner_q;
  logic                     tie_q;
  logic                     timeout_q;
  logic                     busy_q;
  logic                     done_q;

  logic [PID_W-1:0]         nextPlayer_d;
  logic [SCORE_W-1:0]       scanScore;
  logic [NUM_PLAYERS-1:0]   scanHot;
  logic [SCORE_W-1:0]       scanMax_d;
  logic [NUM_PLAYERS-1:0]   scanMask_d;
  logic                     scanTie_d;

  assign nextPlayer_d = (player_q == LAST_PID) ? '0 : player_q + PID_W'(1);
  assign scanScore    = score_q[scanIdx_q];

  // One scan step per EVAL cycle: the first player seeds the running max.
  always_comb begin
    scanHot            = '0;
    scanHot[scanIdx_q] = 1'b1;
    scanMax_d          = max_q;
    scanMask_d         = mask_q;
    if (scanIdx_q == '0) begin
      scanMax_d  = scanScore;
      scanMask_d = scanHot;
    end else if (scanScore > max_q) begin
      scanMax_d  = scanScore;
      scanMask_d = scanHot;
    end else if (scanScore == max_q) begin
      scanMask_d = mask_q | scanHot;
    end
    scanTie_d = (scanMask_d & (scanMask_d - NUM_PLAYERS'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      player_q  <= '0;
      pairs_q   <= '0;
      timer_q   <= '0;
      scanIdx_q <= '0;
      max_q     <= '0;
      mask_q    <= '0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_PLAYERS; k++) score_q[k] <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (start) begin
        state_q   <= PLAY;
        player_q  <= '0;
        pairs_q   <= '0;
        timer_q   <= '0;
        scanIdx_q <= '0;
        max_q     <= '0;
        mask_q    <= '0;
        winner_q  <= '0;
        tie_q     <= 1'b0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) score_q[k] <= '0;
      end else begin
        case (state_q)
          PLAY: begin
            // A finished turn outranks a simultaneous tick and restarts the timer.
            if (turn_valid) begin
              timer_q <= '0;
              if (turn_match) begin
                score_q[player_q] <= score_q[player_q] + SCORE_ONE;
                pairs_q           <= pairs_q + SCORE_ONE;
                if (pairs_q + SCORE_ONE == PAIRS_MAX) begin
                  state_q   <= EVAL;
                  scanIdx_q <= '0;
                end
              end else begin
                player_q <= nextPlayer_d;
              end
            end else if (tick && TIMEOUT_EN) begin
              if (timer_q + 8'd1 == TICKS_MAX) begin
                timer_q   <= '0;
                player_q  <= nextPlayer_d;
                timeout_q <= 1'b1;
              end else begin
                timer_q <= timer_q + 8'd1;
              end
            end
          end
          EVAL: begin
            max_q  <= scanMax_d;
            mask_q <= scanMask_d;
            if (scanIdx_q == LAST_PID) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              winner_q <= scanMask_d;
              tie_q    <= scanTie_d;
            end else begin
              scanIdx_q <= scanIdx_q + PID_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_scores
    assign scores[k*SCORE_W +: SCORE_W] = score_q[k];
  end

  assign current_player = player_q;
  assign pairs_found    = pairs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign winner_mask    = winner_q;
  assign tie            = tie_q;
  assign timeout_pulse  = timeout_q;

endmodule

// File: doc/memory_referee.md
Name: memory_referee

Overview:
- Sequential referee for the memory (pairs) game, parametrised in player count, pair count and turn timeout.
- Sits between the card-compare logic and the VGA scoreboard/result display.
- Tracks whose turn it is, per-player scores and pairs found; passes the turn on a mismatch or a timeout.
- At game end, scans the scores over several cycles and reports a one-hot/multi-hot winner mask plus a tie flag.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- NUM_PAIRS, 8, pairs on the board; the game ends when all are found (1..255).
- TURN_TICKS, 4, number of tick pulses without a turn before the turn is forfeited (1..255; 0 disables the timeout).
- Derived, not overridable: SCORE_W = $clog2(NUM_PAIRS+1); PID_W = max(1, $clog2(NUM_PLAYERS)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: clear all and begin a game (valid in any state)
- turn_valid  in  1  pulse: current player finished a two-card turn
- turn_match  in  1  qualifies turn_valid: 1 = pair found, 0 = mismatch
- tick  in  1  timebase pulse for the turn timeout (e.g. 1 Hz enable)
- current_player  out  PID_W  index of the player whose turn it is
- scores  out  NUM_PLAYERS*SCORE_W  packed scores; player k occupies bits [k*SCORE_W +: SCORE_W]
- pairs_found  out  SCORE_W  total pairs found
- busy  out  1  high in PLAY or EVAL
- done  out  1  high in DONE
- winner_mask  out  NUM_PLAYERS  bit k set means player k holds the top score (valid while done=1)
- tie  out  1  more than one bit of winner_mask is set (valid while done=1)
- timeout_pulse  out  1  one-cycle pulse when a turn is forfeited

Behaviour:
- Clock and reset: one clock domain; all outputs are registered.
- Reset (rst=1): state=IDLE. current_player, scores, pairs_found, winner_mask, tie, timeout_pulse, busy and done are all 0. The turn timer is 0.
- IDLE: turn_valid and tick are ignored. On start -> PLAY.
- Entering PLAY via start (from any state):
  - scores, pairs_found, timer, winner_mask and tie are cleared.
  - current_player=0.
- PLAY, turn_valid=1 at cycle t (results visible at t+1; timer cleared):
  - turn_match=1: scores[current_player]+1, pairs_found+1, current_player unchanged.
  - turn_match=0: current_player advances as (current_player+1) mod NUM_PLAYERS, wrapping NUM_PLAYERS-1 -> 0.
- Timeout (PLAY, TURN_TICKS>0):
  - Each tick with no turn_valid increments the timer.
  - When the tick would make timer==TURN_TICKS: timer clears, current_player advances as on a mismatch, and timeout_pulse=1 for one cycle.
- Simultaneous turn_valid and tick: turn_valid takes priority. The timer clears and no timeout occurs.
- start has priority over turn_valid and tick in the same cycle.
- Game end: the turn_valid that brings pairs_found to NUM_PAIRS moves the FSM to EVAL at t+1.
  - Score and pair counters never exceed NUM_PAIRS. turn_valid in EVAL or DONE is ignored.
- EVAL: scans players k=0..NUM_PLAYERS-1, one per cycle.
  - k=0: max=score0, mask=onehot(0).
  - k>0, score_k>max: max=score_k, mask=onehot(k).
  - k>0, score_k==max: mask |= onehot(k).
  - After the last player -> DONE. winner_mask and tie (popcount(mask)>1) are registered on DONE entry.
  - done=1 at cycle t+1+NUM_PLAYERS.
- DONE: all outputs hold until start (-> PLAY) or rst (-> IDLE).
- Mid-operation restart: start during PLAY or EVAL aborts immediately. The scan is discarded and done stays 0.
- Status mapping: busy = (PLAY or EVAL); done = DONE. They are never both 1.
- NUM_PLAYERS=2 compatibility: the legacy 2-bit result is {winner_mask[1], winner_mask[0]} when done=1, else 00.
  - 01 = player 1 wins, 10 = player 2 wins, 11 = tie.

Test Plan (defaults unless stated):
- Reset/idle: assert rst 2 cycles, then pulse turn_valid, turn_match=1 -> all outputs 0, state stays IDLE, scores=0.
- Turn passing: start; turns mismatch, match, mismatch -> current_player 1, 1, 0; scores={P1=1, P0=0}; pairs_found=1.
- Timeout: start; 4 ticks with no turn -> timeout_pulse once on the 4th tick, current_player=1. Tick and turn_valid in the same cycle -> no timeout, timer cleared.
- Win and latency: P0 finds 5 pairs, P1 finds 3 (interleaved mismatches); last match at cycle t -> done=1 at t+3, winner_mask=01, tie=0, busy=0.
- Tie with wrap: NUM_PLAYERS=3, NUM_PAIRS=8, final scores {3,2,3} -> winner_mask=101, tie=1, done at t+4. Also check the current_player wrap 2 -> 0.
- Restart mid-game and mid-EVAL: start during PLAY with scores nonzero, and start in the EVAL cycle -> next cycle scores=0, pairs_found=0, current_player=0, done=0, busy=1.
